sa_job_ctrl: RTL
================

// Module: sa_job_ctrl
// PURPOSE
//  Job sequencer for one systolic-array matmul. Sits between host control and the
//  AXI-stream dispatcher plus array. Gates input acceptance and counts beats in and out.
//  Waits for the array's done signal, with a timeout, then returns the array to a clean state.
//  Reports per-job status: busy, done pulse, error code and cycle count.
// PARAMETERS
//  M          2     rows of A / rows of C
//  N          3     inner dimension
//  K          2     columns of B / columns of C (M==K)
//  BW         2     32-bit words per stream beat (even, >=2)
//  TIMEOUT    1024  max COMPUTE cycles before abort with error
//  CLR_CYC    4     cycles sa_clr is held in CLEAR
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous reset, active-high
//  start      in   1   1-cycle job request; honoured only in IDLE
//  abort      in   1   level; forces CLEAR from LOAD/COMPUTE/DRAIN
//  in_beat    in   1   in_valid & in_ready of the input stream (beat accepted)
//  out_beat   in   1   out_valid & out_ready of the output stream
//  sa_done    in   1   array computation finished
//  sa_err     in   1   array error
//  in_en      out  1   permits input acceptance (ANDed into in_ready)
//  drain_en   out  1   permits output streaming
//  sa_clr     out  1   clears dispatcher counters, FIFOs and array accumulators
//  busy       out  1   high in any state other than IDLE
//  job_done   out  1   1-cycle pulse on CLEAR->IDLE
//  err_code   out  2   0 ok, 1 sa_err, 2 timeout, 3 abort; held until next start
//  cyc_cnt    out  32  cycles from start to job_done; held until next start
// BEHAVIOUR
//  IN_BEATS = 2*M*N/BW and OUT_BEATS = M*K/BW. Both counters are $clog2(max+1) bits wide.
//  Reset: state=IDLE; all outputs 0; counters 0.
//  States and transitions (one per cycle, registered outputs decoded from state):
//   IDLE: start=1 -> LOAD. On that edge err_code, cyc_cnt and beat counters are cleared.
//   LOAD: in_en=1; in_beat increments in_cnt.
//         When in_beat occurs with in_cnt==IN_BEATS-1 -> COMPUTE. in_en is low the next cycle.
//   COMPUTE: to_cnt increments every cycle.
//         sa_err -> err_code=1, CLEAR.
//         else sa_done -> DRAIN.
//         else to_cnt==TIMEOUT-1 -> err_code=2, CLEAR.
//   DRAIN: drain_en=1; out_beat increments out_cnt.
//         When out_beat occurs with out_cnt==OUT_BEATS-1 -> CLEAR.
//   CLEAR: sa_clr=1 for exactly CLR_CYC cycles, then -> IDLE with job_done=1 for one cycle.
//  abort in LOAD/COMPUTE/DRAIN -> CLEAR with err_code=3. abort has priority over sa_err,
//   sa_done and the beat-count terminal conditions in the same cycle. abort is ignored in IDLE/CLEAR.
//  sa_err in LOAD or DRAIN -> err_code=1, CLEAR. sa_err outranks completion in the same cycle.
//  in_beat outside LOAD and out_beat outside DRAIN are ignored and counted nowhere.
//  start outside IDLE is ignored; no queuing.
//  cyc_cnt counts from the LOAD entry cycle through the final CLEAR cycle and saturates at 2^32-1.
//  Latency: start->in_en 1 cycle. Last in_beat->COMPUTE 1 cycle.
//   sa_done->drain_en 1 cycle. Last out_beat->sa_clr 1 cycle.
//  rst mid-job: immediate IDLE and all outputs 0. The job is lost and no job_done is issued.
//  The rst flop clears the array directly, so no sa_clr pulse is needed.
// TESTING (M=2,N=3,K=2,BW=2,TIMEOUT=16,CLR_CYC=4: IN_BEATS=6, OUT_BEATS=2)
//  1 Normal job: start; 6 in_beats; sa_done 5 cycles later; 2 out_beats.
//    -> sa_clr high 4 cycles, job_done pulse, err_code=0, cyc_cnt equals the measured span.
//  2 Backpressure: gaps between the 6 in_beats and a stalled out_ready.
//    -> state holds, counts exact, no early COMPUTE or CLEAR.
//  3 Timeout: sa_done never asserted -> CLEAR on the 16th COMPUTE cycle, err_code=2, job_done.
//  4 Error: sa_err during COMPUTE -> CLEAR next cycle, err_code=1.
//    sa_err and sa_done in the same cycle -> err_code=1.
//  5 Abort on the 6th in_beat cycle -> CLEAR (not COMPUTE), err_code=3.
//    start during CLEAR is ignored; a later start in IDLE begins a clean job.
//  6 rst asserted in DRAIN -> next cycle busy=0, drain_en=0, job_done=0, err_code=0.
//    Stray in_beat/out_beat in IDLE leave the counters at 0.

Source files
------------

// File: rtl/sa_job_ctrl.sv
// sa_job_ctrl: job sequencer for one systolic-array matmul (load, compute, drain, clear).
module sa_job_ctrl #(
  parameter int M       = 2,
  parameter int N       = 3,
  parameter int K       = 2,
  parameter int BW      = 2,
  parameter int TIMEOUT = 1024,
  parameter int CLR_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_beat,
  input  logic        out_beat,
  input  logic        sa_done,
  input  logic        sa_err,
  output logic        in_en,
  output logic        drain_en,
  output logic        sa_clr,
  output logic        busy,
  output logic        job_done,
  output logic [1:0]  err_code,
  output logic [31:0] cyc_cnt
);
  localparam int IN_BEATS  = 2 * M * N / BW;
  localparam int OUT_BEATS = M * K / BW;
  localparam int IW = $clog2(IN_BEATS + 1);
  localparam int OW = $clog2(OUT_BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CLR_CYC + 1);
  localparam logic [IW-1:0] IN_LAST  = IW'(IN_BEATS - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_BEATS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, CLEAR} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   in_cnt_q, in_cnt_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [1:0]      err_q, err_d;
  logic [31:0]     cyc_q, cyc_d;
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      to_cnt_q  <= '0;
      clr_cnt_q <= '0;
      err_q     <= '0;
      cyc_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      done_q    <= done_d;
    end
  end

  // abort outranks sa_err, which outranks every completion condition
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    to_cnt_d  = (state_q == COMPUTE) ? to_cnt_q + 1'b1 : '0;
    clr_cnt_d = (state_q == CLEAR) ? clr_cnt_q + 1'b1 : '0;
    err_d     = err_q;
    done_d    = 1'b0;
    cyc_d     = (state_q != IDLE && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = LOAD;
        in_cnt_d  = '0;
        out_cnt_d = '0;
        err_d     = 2'd0;
        cyc_d     = '0;
      end
      LOAD: begin
        in_cnt_d = in_beat ? in_cnt_q + 1'b1 : in_cnt_q;
        if (abort) begin state_d = CLEAR; err_d = 2'd3; end
        else if (sa_err) begin state_d = CLEAR; err_d = 2'd1; end
        else if (in_beat && in_cnt_q == IN_LAST) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (abort) begin state_d = CLEAR; err_d = 2'd3; end
        else if (sa_err) begin state_d = CLEAR; err_d = 2'd1; end
        else if (sa_done) state_d = DRAIN;
        else if (to_cnt_q == TO_LAST) begin state_d = CLEAR; err_d = 2'd2; end
      end
      DRAIN: begin
        out_cnt_d = out_beat ? out_cnt_q + 1'b1 : out_cnt_q;
        if (abort) begin state_d = CLEAR; err_d = 2'd3; end
        else if (sa_err) begin state_d = CLEAR; err_d = 2'd1; end
        else if (out_beat && out_cnt_q == OUT_LAST) state_d = CLEAR;
      end
      CLEAR: if (clr_cnt_q == CLR_LAST) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_en    = state_q == LOAD;
  assign drain_en = state_q == DRAIN;
  assign sa_clr   = state_q == CLEAR;
  assign busy     = state_q != IDLE;
  assign job_done = done_q;
  assign err_code = err_q;
  assign cyc_cnt  = cyc_q;
endmodule
